// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: MMIO window constants, register decode and byte-lane merge helpers.
package data_sram_responder_pkg;
  localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hbfaf;
  localparam logic [15:0] LED_OFF = 16'hf020;
  localparam logic [15:0] NUM_OFF = 16'hf050;
  localparam logic [15:0] SWITCH_OFF = 16'hf070;
  localparam logic [15:0] TIMER_OFF = 16'he000;
  localparam logic [15:0] LED_RST = 16'hffff;
  typedef enum logic [2:0] {REG_NONE, REG_LED, REG_NUM, REG_SWITCH, REG_TIMER} mmio_reg_e;
  function automatic mmio_reg_e mmio_decode(input logic [15:0] off);
    return off == LED_OFF ? REG_LED :
           off == NUM_OFF ? REG_NUM :
           off == SWITCH_OFF ? REG_SWITCH :
           off == TIMER_OFF ? REG_TIMER : REG_NONE;
  endfunction
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] we);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/data_sram_responder_sram_byte_ram.sv
// sram_byte_ram: single-port read-first word RAM with byte-lane writes and a registered read port.
module sram_byte_ram #(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**RAM_AW];
  always_ff @(posedge clk)
    if (en)
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rdata <= '0;
    else if (en) rdata <= mem[addr];
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data SRAM slave serving a byte-writable RAM plus LED/NUM/SWITCH/TIMER MMIO registers.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW       = 14,
  parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic [31:0] num_data
);
  logic        mmio;
  logic        mmio_wr;
  mmio_reg_e   sel;
  logic [31:0] timer;
  logic [31:0] timer_inc;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic [31:0] ram_q;
  logic        sel_mmio_q;
  assign mmio = data_sram_addr[31:16] == MMIO_BASE_HI;
  assign sel = mmio_decode(data_sram_addr[15:0]);
  assign mmio_wr = data_sram_en && mmio && |data_sram_we;
  assign timer_inc = timer + 32'd1;
  always_comb
    mmio_rd = sel == REG_LED ? {16'h0, led} :
              sel == REG_NUM ? num_data :
              sel == REG_SWITCH ? {24'h0, switch_in} :
              sel == REG_TIMER ? timer : 32'h0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      led <= LED_RST;
      num_data <= '0;
      timer <= '0;
      mmio_q <= '0;
      sel_mmio_q <= 1'b0;
    end else begin
      timer <= mmio_wr && sel == REG_TIMER ? byte_merge(timer_inc, data_sram_wdata, data_sram_we) : timer_inc;
      if (mmio_wr && sel == REG_LED)
        led <= {data_sram_we[1] ? data_sram_wdata[15:8] : led[15:8], data_sram_we[0] ? data_sram_wdata[7:0] : led[7:0]};
      if (mmio_wr && sel == REG_NUM) num_data <= byte_merge(num_data, data_sram_wdata, data_sram_we);
      if (data_sram_en) sel_mmio_q <= mmio;
      if (data_sram_en && mmio) mmio_q <= mmio_rd;
    end
  sram_byte_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .resetn(resetn),
    .en    (data_sram_en && !mmio),
    .we    (data_sram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_q)
  );
  // Each source holds its own last result, so the registered select alone keeps rdata stable when idle.
  assign data_sram_rdata = sel_mmio_q ? mmio_q : ram_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: scoreboard bench for data_sram_responder; expected rdata queued at request, checked one cycle later.
module tb_data_sram_responder;
  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  data_sram_responder dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch_in      (switch_in),
    .led            (led),
    .num_data       (num_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    data_sram_en = e;
    data_sram_we = w;
    data_sram_addr = a;
    data_sram_wdata = d;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data_sram_rdata !== 32'h0 || led !== 16'hffff || num_data !== 32'h0) begin
      errors++;
      $display("FAIL reset rdata=%h led=%h num=%h required 0/ffff/0", data_sram_rdata, led, num_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    data_sram_en = 1'b1;
    data_sram_we = 4'h0;
    data_sram_addr = 32'hbfafe000;
    exp_q.push_back(32'h0);
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL reset_timer rdata=%h required %h", data_sram_rdata, exp);
    end
  endtask

  task automatic test_byte_write;
    drive(1, 4'hf, 32'h00000100, 32'h11223344);
    drive(1, 4'b0010, 32'h00000100, 32'h0000aa00);
    drive(1, 4'h0, 32'h00000100, 32'h0);
    exp_q.push_back(32'h1122aa44);
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL byte_write rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'h0, 32'h00010100, 32'h0);
    exp_q.push_back(32'h1122aa44);
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL alias rdata=%h required %h", data_sram_rdata, exp);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) drive(1, 4'hf, 32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'h0, 32'(i * 4), 32'h0);
      exp_q.push_back(32'(i + 1));
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (data_sram_rdata !== exp) begin
          errors++;
          $display("FAIL stream[%0d] rdata=%h required %h", i - 1, data_sram_rdata, exp);
        end
      end
    end
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL stream[3] rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(0, 4'h0, 32'h8, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h4) begin
      errors++;
      $display("FAIL idle_hold rdata=%h required %h", data_sram_rdata, 32'h4);
    end
  endtask

  task automatic test_mmio;
    drive(1, 4'hf, 32'h0000f020, 32'h5555aaaa);
    drive(1, 4'hf, 32'hbfaff020, 32'h0000beef);
    drive(1, 4'hf, 32'hbfaff050, 32'h12345678);
    checks++;
    if (led !== 16'hbeef) begin
      errors++;
      $display("FAIL led led=%h required %h", led, 16'hbeef);
    end
    switch_in = 8'h5a;
    drive(1, 4'hf, 32'hbfaf1234, 32'hdeadbeef);
    checks++;
    if (num_data !== 32'h12345678) begin
      errors++;
      $display("FAIL num num_data=%h required %h", num_data, 32'h12345678);
    end
    drive(1, 4'h0, 32'hbfaff070, 32'h0);
    exp_q.push_back(32'h0000005a);
    drive(1, 4'h0, 32'hbfaf1234, 32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL switch rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'h0, 32'hbfaff020, 32'h0);
    exp_q.push_back(32'h0000beef);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL unmapped rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'h0, 32'h0000f020, 32'h0);
    exp_q.push_back(32'h5555aaaa);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL led_read rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'h0, 32'hbfaff050, 32'h0);
    exp_q.push_back(32'h12345678);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL ram_isolated rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL num_read rdata=%h required %h", data_sram_rdata, exp);
    end
  endtask

  task automatic test_timer;
    drive(1, 4'hf, 32'hbfafe000, 32'hfffffffe);
    drive(1, 4'h0, 32'hbfafe000, 32'h0);
    exp_q.push_back(32'hfffffffe);
    drive(1, 4'h0, 32'hbfafe000, 32'h0);
    exp_q.push_back(32'hffffffff);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL timer_load rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'h0, 32'hbfafe000, 32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL timer_inc rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'hf, 32'hbfafe000, 32'h12345600);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL timer_wrap rdata=%h required %h", data_sram_rdata, exp);
    end
    drive(1, 4'b0001, 32'hbfafe000, 32'h00000007);
    drive(1, 4'h0, 32'hbfafe000, 32'h0);
    exp_q.push_back(32'h12345607);
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL timer_byte rdata=%h required %h", data_sram_rdata, exp);
    end
  endtask

  task automatic test_random;
    logic [31:0] mdl [8];
    logic [3:0]  w;
    logic [31:0] d;
    int          k;
    for (int i = 0; i < 8; i++) begin
      mdl[i] = $urandom;
      drive(1, 4'hf, 32'h400 + 32'(i * 4), mdl[i]);
    end
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 7);
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d = $urandom;
      drive(1, w, 32'h400 + 32'(k * 4), d);
      exp_q.push_back(mdl[k]);
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (data_sram_rdata !== exp) begin
          errors++;
          $display("FAIL random[%0d] rdata=%h required %h", i - 1, data_sram_rdata, exp);
        end
      end
      for (int b = 0; b < 4; b++) if (w[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
    end
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL random[59] rdata=%h required %h", data_sram_rdata, exp);
    end
  endtask

  task automatic test_async_reset;
    drive(1, 4'hf, 32'h00000200, 32'hcafef00d);
    drive(1, 4'h0, 32'h00000200, 32'h0);
    exp_q.push_back(32'hcafef00d);
    drive(1, 4'h0, 32'h00000200, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL pre_reset rdata=%h required %h", data_sram_rdata, exp);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (data_sram_rdata !== 32'h0 || led !== 16'hffff) begin
      errors++;
      $display("FAIL async_reset rdata=%h led=%h required 0/ffff", data_sram_rdata, led);
    end
    drive(0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;
    drive(0, 4'h0, 32'h0, 32'h0);
    drive(0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_hold rdata=%h required %h", data_sram_rdata, 32'h0);
    end
    drive(1, 4'h0, 32'h00000200, 32'h0);
    exp_q.push_back(32'hcafef00d);
    drive(0, 4'h0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks++;
    if (data_sram_rdata !== exp) begin
      errors++;
      $display("FAIL post_reset_read rdata=%h required %h", data_sram_rdata, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in = 8'h00;
    test_reset;
    test_byte_write;
    test_back_to_back;
    test_mmio;
    test_timer;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data SRAM interface (en / we / addr / wdata out, rdata back, fixed 1-cycle read latency).
- Serves a byte-writable word RAM plus a small MMIO register window with a free-running timer, LED register and number-display register.
- Sits outside the core in the SoC top. It is the device the core's execute stage issues to and the memory stage reads from.

Parameters:
- RAM_AW, 14, word-address bits of the backing RAM (2^RAM_AW 32-bit words).
- MMIO_BASE_HI, 16'hbfaf, value of addr[31:16] that selects the MMIO window.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  access request this cycle.
- data_sram_we  in  4  byte write enables; 0 means read.
- data_sram_addr  in  32  byte address; addr[1:0] ignored.
- data_sram_wdata  in  32  write data, byte lanes aligned to we bits.
- data_sram_rdata  out  32  read data, valid the cycle after a read request.
- switch_in  in  8  board switches, readable via MMIO.
- led  out  16  LED register.
- num_data  out  32  number-display register.

Behaviour:
- Reset is asynchronous, active-low (resetn); clk is the only clock.
- Reset values: data_sram_rdata=0, led=16'hffff, num_data=0, timer=0. RAM contents are not reset.
- Decode: mmio = (addr[31:16]==MMIO_BASE_HI). Otherwise RAM word index = addr[RAM_AW+1:2]; higher address bits are ignored (aliasing).
- RAM write: when en && we!=0, each byte i with we[i]=1 is written at the clock edge. Unselected bytes are unchanged.
- Read latency: when en && we==0, data_sram_rdata presents the addressed word at the next rising edge (1 cycle). Back-to-back reads every cycle are supported, with no bubbles and no stall.
- Write cycles: rdata also updates with the pre-write (old) word. This is read-first behaviour; the core ignores it.
- When en=0, data_sram_rdata holds its previous value.
- Read-after-write to the same address in consecutive cycles returns the newly written data.
- MMIO map (offset = addr[15:0]):
  - 16'hf020 LED: bytes 0-1 writable; rdata={16'b0,led}.
  - 16'hf050 NUM: all 4 bytes writable per we.
  - 16'hf070 SWITCH: read-only; rdata={24'b0,switch_in}, sampled in the request cycle.
  - 16'he000 TIMER: read/write per-byte.
  - Any other offset: reads return 0, writes are ignored.
- Timer: increments by 1 every cycle and wraps 32'hffffffff -> 0.
  - A write in the same cycle takes priority: written bytes are loaded from wdata, unwritten bytes take the incremented value.
  - A read returns the timer value held during the request cycle (pre-increment).
- MMIO writes never touch RAM, and RAM accesses never touch MMIO.
- Reset asserted mid-operation clears all registers immediately. A pending read result is lost and rdata is forced to 0. An in-flight RAM write in that cycle is not guaranteed.

Decomposition:
- Shared package/header (alongside mycpu.vh) holds MMIO_BASE_HI, the offsets LED_OFF / NUM_OFF / SWITCH_OFF / TIMER_OFF, and the reset value of LED.
- One sub-module, sram_byte_ram: single-port, read-first, 4 byte-lane write-enable RAM with a registered read port, parameterised by RAM_AW.
- The top of this block does decode, MMIO registers, the timer, and the registered output mux. The mux is selected by the decode registered in the request cycle.

Test Plan:
- Reset then idle: resetn low 3 cycles -> rdata=0, led=16'hffff, num_data=0. Timer reads 0 in the first request cycle after release.
- Byte writes: write 32'h11223344 we=4'hf to 0x00000100, then we=4'b0010 with wdata 32'h0000aa00, then read 0x100 -> rdata=32'h1122aa44 exactly one cycle after the read request.
- Streaming reads: preload words 0x0..0xC with 1..4 and issue 4 consecutive reads -> rdata=1,2,3,4 on the 4 following cycles. Drop en for one cycle -> rdata holds 4.
- MMIO: write 32'h0000beef to 0xbfaff020 -> led=16'hbeef. Write 0x12345678 to 0xbfaff050 -> num_data=0x12345678. switch_in=8'h5a, read 0xbfaff070 -> 0x0000005a. Read 0xbfaf1234 -> 0.
- Timer: write 32'hfffffffe with we=4'hf, then read in the next two cycles -> rdata = 0xfffffffe then 0xffffffff; the following read -> 0 (wrap). A write with we=4'b0001 and wdata 0x7 loads byte 0 only.
- Async reset mid-stream: assert resetn low between a read request and its response edge -> rdata goes to 0 asynchronously and stays 0 after release until the next read.
